// File: rtl/pease_fft.sv
// pease_fft: iterative radix-2 constant-geometry (Pease) FFT on N real samples.
// Bit-reverses the input frame into a complex work array, then runs one bank of
// N/2 butterflies once per cycle for log2(N) stages. The real part of the
// spectrum is returned in natural order.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   recv_msg/val/rdy    input frame x[0..N-1], natural order
//   send_msg/val/rdy    output frame Re(X[0..N-1]), natural order
module pease_fft #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned DECIMAL_PT = 16,
  parameter int unsigned N_SAMPLES  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg,
  output logic                                send_val,
  input  logic                                send_rdy
);

  localparam int unsigned LOG_N   = $clog2(N_SAMPLES);
  localparam int unsigned HALF_N  = N_SAMPLES / 2;
  localparam int unsigned STAGE_W = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] word_arr_t;
  typedef logic signed [BIT_WIDTH-1:0]         word_t;

  localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1) << DECIMAL_PT;

  // S[k] = round(sin(2*pi*k/N) * 2^DECIMAL_PT), rounded half away from zero.
  function automatic word_arr_t gen_sin_table();
    word_arr_t tab;
    real       ang;
    real       v;
    tab = '0;
    for (int k = 0; k < int'(N_SAMPLES); k++) begin
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N_SAMPLES);
      v   = $sin(ang) * (2.0 ** real'(DECIMAL_PT));
      if (v >= 0.0) tab[k] = BIT_WIDTH'($rtoi(v + 0.5));
      else          tab[k] = BIT_WIDTH'(-$rtoi(0.5 - v));
    end
    return tab;
  endfunction

  // Cosine is the sine table rotated by a quarter turn; N=2 has no quarter
  // entry, so its two cosines are written out.
  function automatic word_arr_t gen_cos_table(input word_arr_t s);
    word_arr_t tab;
    tab = '0;
    for (int k = 0; k < int'(N_SAMPLES); k++) begin
      if (N_SAMPLES >= 4) tab[k] = s[(k + int'(N_SAMPLES / 4)) % int'(N_SAMPLES)];
      else                tab[k] = (k == 0) ? ONE : -ONE;
    end
    return tab;
  endfunction

  localparam word_arr_t SIN_TAB = gen_sin_table();
  localparam word_arr_t COS_TAB = gen_cos_table(SIN_TAB);

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    return {<<{v}};
  endfunction

  // Fixed-point multiply: full signed product, floor shift, keep low word.
  function automatic word_t mul(input word_t x, input word_t y);
    logic signed [2*BIT_WIDTH-1:0] xe;
    logic signed [2*BIT_WIDTH-1:0] ye;
    logic signed [2*BIT_WIDTH-1:0] p;
    xe = {{BIT_WIDTH{x[BIT_WIDTH-1]}}, x};
    ye = {{BIT_WIDTH{y[BIT_WIDTH-1]}}, y};
    p  = xe * ye;
    return BIT_WIDTH'(p >>> DECIMAL_PT);
  endfunction

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t             state;
  logic [STAGE_W-1:0] stage;
  word_arr_t          r_re;
  word_arr_t          r_im;
  word_arr_t          nxt_re;
  word_arr_t          nxt_im;

  logic [LOG_N-1:0]   shamt;
  logic [LOG_N-1:0]   tw_k;
  word_t              a_re, a_im, b_re, b_im, w_re, w_im, t_re, t_im;

  assign recv_rdy = (state == IDLE);
  assign send_val = (state == DONE);

  // Butterfly bank for the current stage: pairs (2i, 2i+1) -> (i, i+N/2).
  always_comb begin
    nxt_re = r_re;
    nxt_im = r_im;
    shamt  = LOG_N'(LOG_N - 1) - LOG_N'(stage);
    tw_k   = '0;
    a_re   = '0;
    a_im   = '0;
    b_re   = '0;
    b_im   = '0;
    w_re   = '0;
    w_im   = '0;
    t_re   = '0;
    t_im   = '0;
    for (int i = 0; i < int'(HALF_N); i++) begin
      tw_k = (LOG_N'(i) >> shamt) << shamt;
      w_re = COS_TAB[tw_k];
      w_im = -SIN_TAB[tw_k];
      a_re = r_re[2*i];
      a_im = r_im[2*i];
      b_re = r_re[2*i+1];
      b_im = r_im[2*i+1];
      t_re = mul(w_re, b_re) - mul(w_im, b_im);
      t_im = mul(w_re, b_im) + mul(w_im, b_re);
      nxt_re[i]                = a_re + t_re;
      nxt_im[i]                = a_im + t_im;
      nxt_re[i + int'(HALF_N)] = a_re - t_re;
      nxt_im[i + int'(HALF_N)] = a_im - t_im;
    end
  end

  // Control and datapath registers: load, iterate stages, hold result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      stage    <= '0;
      r_re     <= '0;
      r_im     <= '0;
      send_msg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (recv_val) begin
            for (int i = 0; i < int'(N_SAMPLES); i++) begin
              r_re[i] <= recv_msg[bitrev(LOG_N'(i))];
            end
            r_im  <= '0;
            stage <= '0;
            state <= COMP;
          end
        end
        COMP: begin
          r_re <= nxt_re;
          r_im <= nxt_im;
          if (stage == STAGE_W'(LOG_N - 1)) begin
            send_msg <= nxt_re;
            stage    <= '0;
            state    <= DONE;
          end else begin
            stage <= stage + STAGE_W'(1);
          end
        end
        DONE: begin
          if (send_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pease_fft.sv
// Scoreboard bench for pease_fft (N=8, 32-bit words, 16 fractional bits).
module tb_pease_fft;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned DP = 16;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    frame_t v;
    int     tol;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  frame_t recv_msg;
  logic   recv_val;
  logic   recv_rdy;
  frame_t send_msg;
  logic   send_val;
  logic   send_rdy;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_checks = 0;
  int     n_errs   = 0;
  int     frame_no = 0;

  always #5 clk = ~clk;

  pease_fft #(.BIT_WIDTH(W), .DECIMAL_PT(DP), .N_SAMPLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp, input int tol);
    int d;
    d = $signed(act - exp);
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic frame_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int x4, input int x5, input int x6, input int x7);
    frame_t f;
    f[0] = W'(x0); f[1] = W'(x1); f[2] = W'(x2); f[3] = W'(x3);
    f[4] = W'(x4); f[5] = W'(x5); f[6] = W'(x6); f[7] = W'(x7);
    return f;
  endfunction

  // Monitor: every output handshake pops one expected frame.
  always @(negedge clk) begin
    if (!reset && send_val && send_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_output: got a frame, expected none");
      end else begin
        mon_e = sb.pop_front();
        for (int i = 0; i < int'(N); i++)
          check($sformatf("frame%0d_X%0d", frame_no, i), send_msg[i], mon_e.v[i], mon_e.tol);
        frame_no++;
      end
    end
  end

  // Waits for recv_rdy, presents one frame for one accept edge.
  task automatic issue(input frame_t x, input frame_t ex, input int tol, input bit push);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!recv_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!recv_rdy) begin
      n_checks++;
      n_errs++;
      $display("FAIL issue_timeout: recv_rdy=0, expected 1");
      return;
    end
    recv_msg = x;
    recv_val = 1'b1;
    if (push) begin
      e.v   = ex;
      e.tol = tol;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    recv_val = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain_timeout: %0d frames pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  localparam int P  = 65536;
  localparam int C  = 46341;

  frame_t impulse, dc, alt, cosv, sinv, ramp, dly;
  frame_t e_imp, e_dc, e_alt, e_cos, e_zero, e_ramp, e_dly;

  initial begin
    int waited;
    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b1;

    impulse = mk(P, 0, 0, 0, 0, 0, 0, 0);
    e_imp   = mk(P, P, P, P, P, P, P, P);
    dc      = mk(P, P, P, P, P, P, P, P);
    e_dc    = mk(8*P, 0, 0, 0, 0, 0, 0, 0);
    alt     = mk(P, -P, P, -P, P, -P, P, -P);
    e_alt   = mk(0, 0, 0, 0, 8*P, 0, 0, 0);
    cosv    = mk(P, C, 0, -C, -P, -C, 0, C);
    e_cos   = mk(0, 4*P, 0, 0, 0, 0, 0, 4*P);
    sinv    = mk(0, C, P, C, 0, -C, -P, -C);
    e_zero  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    ramp    = mk(0, P, 2*P, 3*P, 4*P, 5*P, 6*P, 7*P);
    e_ramp  = mk(28*P, -4*P, -4*P, -4*P, -4*P, -4*P, -4*P, -4*P);
    dly     = mk(0, P, 0, 0, 0, 0, 0, 0);
    e_dly   = mk(P, C, 0, -C, -P, -C, 0, C);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_recv_rdy", W'(recv_rdy), 32'd1, 0);
    check("reset_send_val", W'(send_val), 32'd0, 0);
    for (int i = 0; i < int'(N); i++)
      check($sformatf("reset_send_msg%0d", i), send_msg[i], 32'd0, 0);

    // Impulse, with send_val timing relative to the accept edge.
    issue(impulse, e_imp, 0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("latency_cycle%0d_send_val", c), W'(send_val), (c == 4) ? 32'd1 : 32'd0, 0);
    end
    drain();

    // Back-to-back frames at the minimum period.
    issue(dc,   e_dc,   1, 1'b1);
    issue(alt,  e_alt,  1, 1'b1);
    issue(cosv, e_cos,  4, 1'b1);
    issue(sinv, e_zero, 4, 1'b1);
    issue(ramp, e_ramp, 4, 1'b1);
    issue(dly,  e_dly,  2, 1'b1);
    drain();

    // Backpressure: result must hold while a new frame is offered and ignored.
    send_rdy = 1'b0;
    issue(ramp, e_ramp, 4, 1'b1);
    waited = 0;
    while (!send_val && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!send_val) begin
      n_checks++;
      n_errs++;
      $display("FAIL bp_wait_send_val: send_val=0, expected 1");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      recv_msg = impulse;
      recv_val = 1'b1;
      check($sformatf("bp%0d_send_val", c), W'(send_val), 32'd1, 0);
      check($sformatf("bp%0d_recv_rdy", c), W'(recv_rdy), 32'd0, 0);
      check($sformatf("bp%0d_X0", c), send_msg[0], e_ramp[0], 4);
      check($sformatf("bp%0d_X5", c), send_msg[5], e_ramp[5], 4);
    end
    @(posedge clk);
    #1;
    send_rdy = 1'b1;
    recv_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_recv_rdy", W'(recv_rdy), 32'd1, 0);
    check("bp_release_send_val", W'(send_val), 32'd0, 0);
    drain();

    // Reset while computing stage 1 discards the frame and clears the output.
    issue(cosv, e_cos, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_recv_rdy", W'(recv_rdy), 32'd1, 0);
    check("midreset_send_val", W'(send_val), 32'd0, 0);
    for (int i = 0; i < int'(N); i++)
      check($sformatf("midreset_send_msg%0d", i), send_msg[i], 32'd0, 0);
    issue(cosv, e_cos, 4, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
